// File: rtl/grid_pixel_addresser_if.sv
// Pixel-stream bus between the VGA counter/game-logic side and the grid
// pixel addresser.
//   Counter inputs : h_count, v_count, h_sync_in, v_sync_in
//   Board writes   : wr_en, wr_col, wr_row, wr_data, clear_req
//   Render outputs : in_grid, visible, cell_col, cell_row, sprite_addr,
//                    cell_state, h_sync_out, v_sync_out, clear_busy
interface grid_pixel_addresser_if;
  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        h_sync_in;
  logic        v_sync_in;
  logic        wr_en;
  logic [3:0]  wr_col;
  logic [3:0]  wr_row;
  logic [1:0]  wr_data;
  logic        clear_req;
  logic        clear_busy;
  logic        in_grid;
  logic        visible;
  logic [3:0]  cell_col;
  logic [3:0]  cell_row;
  logic [10:0] sprite_addr;
  logic [1:0]  cell_state;
  logic        h_sync_out;
  logic        v_sync_out;

  modport master (
    output h_count, v_count, h_sync_in, v_sync_in,
    output wr_en, wr_col, wr_row, wr_data, clear_req,
    input  clear_busy, in_grid, visible, cell_col, cell_row,
    input  sprite_addr, cell_state, h_sync_out, v_sync_out
  );

  modport slave (
    input  h_count, v_count, h_sync_in, v_sync_in,
    input  wr_en, wr_col, wr_row, wr_data, clear_req,
    output clear_busy, in_grid, visible, cell_col, cell_row,
    output sprite_addr, cell_state, h_sync_out, v_sync_out
  );
endinterface

// File: rtl/grid_pixel_addresser.sv
// Grid pixel addresser: incrementally tracks cell column/row and intra-cell
// offsets from the VGA counters and emits, two clocks later, the sprite ROM
// address, the cell state from an internal board RAM, visibility and
// delay-matched syncs. A sweep FSM zeroes the board after reset or on
// clear_req.
//   clk_25  : pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : grid_pixel_addresser_if.slave (counters, board writes, outputs)
module grid_pixel_addresser #(
  parameter int unsigned GRID_X0   = 145,
  parameter int unsigned GRID_Y0   = 30,
  parameter int unsigned CELL_W    = 35,
  parameter int unsigned CELL_H    = 35,
  parameter int unsigned GRID_COLS = 10,
  parameter int unsigned GRID_ROWS = 10
) (
  input  logic                   clk_25,
  input  logic                   reset_n,
  grid_pixel_addresser_if.slave  bus
);
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned CIDX_W = 4;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CELLS  = GRID_COLS * GRID_ROWS;

  localparam logic [CNT_W-1:0]  X_FIRST  = CNT_W'(GRID_X0);
  localparam logic [CNT_W-1:0]  X_LAST   = CNT_W'(GRID_X0 + CELL_W * GRID_COLS - 1);
  localparam logic [CNT_W-1:0]  Y_FIRST  = CNT_W'(GRID_Y0);
  localparam logic [CNT_W-1:0]  Y_LAST   = CNT_W'(GRID_Y0 + CELL_H * GRID_ROWS - 1);
  localparam logic [CNT_W-1:0]  H_VIS    = CNT_W'(640);
  localparam logic [CNT_W-1:0]  V_VIS    = CNT_W'(480);
  localparam logic [OFF_W-1:0]  X_WRAP   = OFF_W'(CELL_W - 1);
  localparam logic [OFF_W-1:0]  Y_WRAP   = OFF_W'(CELL_H - 1);
  localparam logic [CIDX_W-1:0] COLS_C   = CIDX_W'(GRID_COLS);
  localparam logic [CIDX_W-1:0] ROWS_C   = CIDX_W'(GRID_ROWS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CELLS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_clear_busy;
  logic                w_clr_we;
  logic                w_busy_nxt;

  logic [OFF_W-1:0]    r_x_off, r_y_off;
  logic [CIDX_W-1:0]   r_col, r_row;
  logic                r_in_grid_s1, r_vis_s1, r_hs_s1, r_vs_s1;

  logic                r_in_grid, r_visible, r_h_sync_out, r_v_sync_out;
  logic [CIDX_W-1:0]   r_cell_col, r_cell_row;
  logic [ADDR_W-1:0]   r_sprite_addr;
  logic [1:0]          r_cell_state;

  logic [1:0]          r_mem [CELLS];

  logic                w_x_in, w_y_in, w_user_we, w_we;
  logic [IDX_W-1:0]    w_rd_idx, w_user_idx, w_wr_idx;
  logic [1:0]          w_wr_data;
  logic [ADDR_W-1:0]   w_sprite;

  assign w_x_in = (bus.h_count >= X_FIRST) && (bus.h_count <= X_LAST);
  assign w_y_in = (bus.v_count >= Y_FIRST) && (bus.v_count <= Y_LAST);

  // Stage 1: incremental column/row and offset tracking
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_x_off      <= '0;
      r_col        <= '0;
      r_y_off      <= '0;
      r_row        <= '0;
      r_in_grid_s1 <= 1'b0;
      r_vis_s1     <= 1'b0;
      r_hs_s1      <= 1'b0;
      r_vs_s1      <= 1'b0;
    end else begin
      if (bus.h_count == X_FIRST) begin
        r_x_off <= '0;
        r_col   <= '0;
      end else if ((bus.h_count > X_FIRST) && (bus.h_count <= X_LAST)) begin
        if (r_x_off == X_WRAP) begin
          r_x_off <= '0;
          r_col   <= r_col + CIDX_W'(1);
        end else begin
          r_x_off <= r_x_off + OFF_W'(1);
        end
      end
      // Rows advance once per line, at the pixel where v_count may change
      if (bus.h_count == '0) begin
        if (bus.v_count == Y_FIRST) begin
          r_y_off <= '0;
          r_row   <= '0;
        end else if ((bus.v_count > Y_FIRST) && (bus.v_count <= Y_LAST)) begin
          if (r_y_off == Y_WRAP) begin
            r_y_off <= '0;
            r_row   <= r_row + CIDX_W'(1);
          end else begin
            r_y_off <= r_y_off + OFF_W'(1);
          end
        end
      end
      r_in_grid_s1 <= w_x_in && w_y_in;
      r_vis_s1     <= (bus.h_count < H_VIS) && (bus.v_count < V_VIS);
      r_hs_s1      <= bus.h_sync_in;
      r_vs_s1      <= bus.v_sync_in;
    end
  end

  assign w_rd_idx = IDX_W'(32'(r_row) * GRID_COLS + 32'(r_col));
  assign w_sprite = ADDR_W'(32'(r_x_off) + 32'(r_y_off) * CELL_W);

  // Stage 2: output registers and board read, zeroed outside the grid
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_in_grid     <= 1'b0;
      r_visible     <= 1'b0;
      r_h_sync_out  <= 1'b0;
      r_v_sync_out  <= 1'b0;
      r_cell_col    <= '0;
      r_cell_row    <= '0;
      r_sprite_addr <= '0;
      r_cell_state  <= '0;
    end else begin
      r_in_grid     <= r_in_grid_s1;
      r_visible     <= r_vis_s1;
      r_h_sync_out  <= r_hs_s1;
      r_v_sync_out  <= r_vs_s1;
      r_cell_col    <= r_in_grid_s1 ? r_col : '0;
      r_cell_row    <= r_in_grid_s1 ? r_row : '0;
      r_sprite_addr <= r_in_grid_s1 ? w_sprite : '0;
      r_cell_state  <= (r_in_grid_s1 && (r_state == S_IDLE)) ? r_mem[w_rd_idx] : '0;
    end
  end

  // Clear FSM: state register
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) r_state <= S_CLEAR;
    else          r_state <= w_state_nxt;
  end

  // Clear FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.clear_req) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_idx == LAST_IDX) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    w_clr_we   = 1'b0;
    w_busy_nxt = 1'b0;
    if (r_state == S_CLEAR)     w_clr_we   = 1'b1;
    if (w_state_nxt == S_CLEAR) w_busy_nxt = 1'b1;
  end

  // Sweep index and registered busy flag
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_idx        <= '0;
      r_clear_busy <= 1'b1;
    end else begin
      r_idx        <= (w_clr_we && (r_idx != LAST_IDX)) ? r_idx + IDX_W'(1) : '0;
      r_clear_busy <= w_busy_nxt;
    end
  end

  // Board write port: sweep has priority, user writes only when idle
  assign w_user_idx = IDX_W'(32'(bus.wr_row) * GRID_COLS + 32'(bus.wr_col));
  assign w_user_we  = bus.wr_en && !bus.clear_req && (r_state == S_IDLE) &&
                      (bus.wr_col < COLS_C) && (bus.wr_row < ROWS_C);
  assign w_we       = w_clr_we || w_user_we;
  assign w_wr_idx   = w_clr_we ? r_idx : w_user_idx;
  assign w_wr_data  = w_clr_we ? 2'b00 : bus.wr_data;

  // Board RAM, read-first (the stage-2 read sees the pre-write value)
  always_ff @(posedge clk_25) begin
    if (w_we) r_mem[w_wr_idx] <= w_wr_data;
  end

  assign bus.clear_busy  = r_clear_busy;
  assign bus.in_grid     = r_in_grid;
  assign bus.visible     = r_visible;
  assign bus.cell_col    = r_cell_col;
  assign bus.cell_row    = r_cell_row;
  assign bus.sprite_addr = r_sprite_addr;
  assign bus.cell_state  = r_cell_state;
  assign bus.h_sync_out  = r_h_sync_out;
  assign bus.v_sync_out  = r_v_sync_out;
endmodule

// File: tb/tb_grid_pixel_addresser.sv
// Directed bench for grid_pixel_addresser: a pixel vector table checked
// against hand-computed values, plus sequences for RAM timing, clearing,
// reset restart and sync alignment. Lines that are not inspected are
// skipped quickly (h jumps to 799, then 0 with the next v) so the row
// tracker still sees every line start.
module tb_grid_pixel_addresser;
  logic clk_25  = 1'b0;
  logic reset_n = 1'b0;

  grid_pixel_addresser_if u_if();

  grid_pixel_addresser u_dut (
    .clk_25  (clk_25),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    int h; int v; int ig; int vis; int col; int row; int sa; int st;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cur_h  = 0;
  int cur_v  = 0;

  bit p_wr = 1'b0; int p_col = 0; int p_row = 0; int p_data = 0;
  bit p_clr = 1'b0; bit p_hs = 1'b0; bit p_vs = 1'b0;
  bit hist_hs [3];
  bit hist_vs [3];

  int s_busy, s_ig, s_vis, s_col, s_row, s_sa, s_st, s_hs, s_vs;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Sample outputs, then apply the next counter value and any pending write
  task automatic drive(input int h, input int v);
    @(negedge clk_25);
    s_busy = int'(u_if.clear_busy);  s_ig  = int'(u_if.in_grid);
    s_vis  = int'(u_if.visible);     s_col = int'(u_if.cell_col);
    s_row  = int'(u_if.cell_row);    s_sa  = int'(u_if.sprite_addr);
    s_st   = int'(u_if.cell_state);  s_hs  = int'(u_if.h_sync_out);
    s_vs   = int'(u_if.v_sync_out);
    u_if.h_count   = 11'(h);
    u_if.v_count   = 11'(v);
    u_if.h_sync_in = p_hs;
    u_if.v_sync_in = p_vs;
    u_if.wr_en     = p_wr;
    u_if.wr_col    = 4'(p_col);
    u_if.wr_row    = 4'(p_row);
    u_if.wr_data   = 2'(p_data);
    u_if.clear_req = p_clr;
    p_wr  = 1'b0;
    p_clr = 1'b0;
    hist_hs[2] = hist_hs[1]; hist_hs[1] = hist_hs[0]; hist_hs[0] = p_hs;
    hist_vs[2] = hist_vs[1]; hist_vs[1] = hist_vs[0]; hist_vs[0] = p_vs;
    cur_h = h;
    cur_v = v;
  endtask

  task automatic step();
    if (cur_h == 799) drive(0, (cur_v == 524) ? 0 : cur_v + 1);
    else              drive(cur_h + 1, cur_v);
  endtask

  task automatic next_line();
    drive(799, cur_v);
    drive(0, (cur_v == 524) ? 0 : cur_v + 1);
  endtask

  task automatic goto_px(input int h, input int v);
    if (cur_v == v && cur_h > h) next_line();
    while (cur_v != v) next_line();
    while (cur_h < h) step();
  endtask

  // Two more pixels so the sample taken in the last drive belongs to the target
  task automatic settle();
    step();
    step();
  endtask

  task automatic sched_write(input int c, input int r, input int d);
    p_wr = 1'b1; p_col = c; p_row = r; p_data = d;
  endtask

  vec_t vecs [16];
  int   first_low;
  int   mis_h, mis_v;

  initial begin
    vecs[0]  = '{145,  30, 1, 1, 0, 0,    0, 0};
    vecs[1]  = '{144,  31, 0, 1, 0, 0,    0, 0};
    vecs[2]  = '{179,  64, 1, 1, 0, 0, 1224, 0};
    vecs[3]  = '{180,  65, 1, 1, 1, 1,    0, 0};
    vecs[4]  = '{215,  70, 1, 1, 2, 1,  175, 0};
    vecs[5]  = '{300, 100, 1, 1, 4, 2,   15, 0};
    vecs[6]  = '{494, 200, 1, 1, 9, 4, 1084, 0};
    vecs[7]  = '{495, 250, 0, 1, 0, 0,    0, 0};
    vecs[8]  = '{250, 275, 1, 1, 3, 7,    0, 2};
    vecs[9]  = '{400, 300, 1, 1, 7, 7,  885, 0};
    vecs[10] = '{145, 310, 1, 1, 0, 8,    0, 0};
    vecs[11] = '{494, 379, 1, 1, 9, 9, 1224, 0};
    vecs[12] = '{200, 380, 0, 1, 0, 0,    0, 0};
    vecs[13] = '{639, 479, 0, 1, 0, 0,    0, 0};
    vecs[14] = '{100, 480, 0, 0, 0, 0,    0, 0};
    vecs[15] = '{640,  10, 0, 0, 0, 0,    0, 0};

    u_if.h_count = '0;  u_if.v_count = '0;
    u_if.h_sync_in = 1'b0; u_if.v_sync_in = 1'b0;
    u_if.wr_en = 1'b0; u_if.wr_col = '0; u_if.wr_row = '0; u_if.wr_data = '0;
    u_if.clear_req = 1'b0;
    for (int i = 0; i < 3; i++) begin hist_hs[i] = 1'b0; hist_vs[i] = 1'b0; end

    // Reset state
    repeat (3) step();
    check("rst_busy",   s_busy, 1);
    check("rst_ingrid", s_ig,   0);
    check("rst_visible",s_vis,  0);
    check("rst_sprite", s_sa,   0);
    check("rst_state",  s_st,   0);
    check("rst_hsync",  s_hs,   0);

    // Post-reset sweep length
    reset_n   = 1'b1;
    first_low = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (s_busy == 0) begin first_low = i; break; end
    end
    check("reset_sweep_len", first_low, 100);

    // Board writes: one valid, two out of range that would alias if accepted
    sched_write(3, 7, 2);  step();
    sched_write(10, 7, 3); step();
    sched_write(12, 0, 1); step();

    // Pixel vector table
    for (int i = 0; i < 16; i++) begin
      goto_px(vecs[i].h, vecs[i].v);
      settle();
      check($sformatf("vec%0d_ingrid", i), s_ig,  vecs[i].ig);
      check($sformatf("vec%0d_visible",i), s_vis, vecs[i].vis);
      check($sformatf("vec%0d_col", i),    s_col, vecs[i].col);
      check($sformatf("vec%0d_row", i),    s_row, vecs[i].row);
      check($sformatf("vec%0d_sprite", i), s_sa,  vecs[i].sa);
      check($sformatf("vec%0d_state", i),  s_st,  vecs[i].st);
    end

    // Write landing on the same edge as the read: old value, then new value
    goto_px(330, 320);
    sched_write(5, 8, 1);
    settle();
    check("rw_same_sprite", s_sa, 360);
    check("rw_same_old",    s_st, 0);
    goto_px(330, 321);
    settle();
    check("rw_next_new",    s_st, 1);

    // Clear together with a write; write mid-sweep; state forced during sweep
    goto_px(239, 275);
    p_clr = 1'b1;
    sched_write(2, 2, 3);
    drive(240, 275);
    first_low = 0;
    for (int i = 1; i <= 300; i++) begin
      if (i == 50) sched_write(2, 2, 3);
      step();
      if (i == 12) begin
        check("sweep_ingrid_px250", s_ig, 1);
        check("sweep_state_forced", s_st, 0);
      end
      if (s_busy == 0) begin first_low = i; break; end
    end
    check("clear_req_sweep_len", first_low, 101);
    goto_px(250, 276);
    settle();
    check("cleared_cell_3_7", s_st, 0);
    goto_px(215, 100);
    settle();
    check("dropped_write_2_2", s_st, 0);

    // Sync alignment over two full lines with random sync patterns
    next_line();
    mis_h = 0;
    mis_v = 0;
    for (int i = 0; i < 1600; i++) begin
      p_hs = 1'($urandom_range(1, 0));
      p_vs = 1'($urandom_range(1, 0));
      step();
      if (s_hs != int'(hist_hs[2])) mis_h++;
      if (s_vs != int'(hist_vs[2])) mis_v++;
    end
    p_hs = 1'b0;
    p_vs = 1'b0;
    check("h_sync_delay_mismatches", mis_h, 0);
    check("v_sync_delay_mismatches", mis_v, 0);

    // Reset during a sweep at index 50 restarts it from index 0
    p_clr = 1'b1;
    step();
    repeat (51) step();
    reset_n = 1'b0;
    step();
    check("midsweep_rst_busy", s_busy, 1);
    repeat (2) step();
    reset_n   = 1'b1;
    first_low = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (s_busy == 0) begin first_low = i; break; end
    end
    check("restart_sweep_len", first_low, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grid_pixel_addresser.md
# grid_pixel_addresser

Upstream address-generation stage for the VGA grid renderer. It tracks the column, row and intra-cell pixel offsets of the 10x10 board incrementally as the horizontal/vertical counters advance, so the renderer needs no modulo or divide. Per pixel it emits the 35x35 sprite ROM address, the cell's game state from an internal board RAM, and delay-matched sync and visibility, all from one registered pipeline. Game logic writes the board RAM through a simple write port. A sweep FSM clears the RAM after reset or on request.

## Interface
- GRID_X0, 145, first grid pixel column (inclusive)
- GRID_Y0, 30, first grid pixel line (inclusive)
- CELL_W, 35, cell width in pixels
- CELL_H, 35, cell height in pixels
- GRID_COLS, 10, cells per row
- GRID_ROWS, 10, cells per column
- clk_25  in  1  pixel clock, 25 MHz; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- h_count  in  11  horizontal counter, 0..799, visible 0..639
- v_count  in  11  vertical counter, 0..524, visible 0..479
- h_sync_in, v_sync_in  in  1 each  sync pulses aligned with the counters
- wr_en  in  1  board write strobe
- wr_col, wr_row  in  4 each  target cell
- wr_data  in  2  cell state to write
- clear_req  in  1  one-cycle pulse; starts a board clear
- clear_busy  out  1  high while a clear sweep is running
- in_grid  out  1  the pixel lies inside the grid
- visible  out  1  h_count<640 and v_count<480
- cell_col, cell_row  out  4 each  cell containing the pixel
- sprite_addr  out  11  x_off + CELL_W*y_off, range 0..1224
- cell_state  out  2  board content for (cell_row, cell_col)
- h_sync_out, v_sync_out  out  1 each  sync delayed to match the data

## Operation
- Input contract: h_count increments by 1 every clk_25 and wraps to 0 after 799. v_count changes only in the cycle where h_count becomes 0.
- Stage 1 register update at edge k, using the h_count and v_count sampled at that edge:
  - Column tracking: if h_count==GRID_X0, x_off<=0 and col<=0. Otherwise, if GRID_X0<h_count<=GRID_X0+CELL_W*GRID_COLS-1, x_off increments. When x_off would pass CELL_W-1, it goes to 0 and col increments.
  - Row tracking, evaluated only when h_count==0: if v_count==GRID_Y0, y_off<=0 and row<=0. Otherwise, if v_count is inside the grid, y_off increments and wraps the same way, with row incrementing on the wrap.
  - Outside these conditions the offsets hold their values.
  - in_grid_s1 is the x-range test AND the y-range test, using the same inclusive bounds as the renderer.
- Stage 2 registers sprite_addr, cell_col/row, in_grid, visible and sync from stage 1. It also reads the board RAM at row*GRID_COLS+col.
- When in_grid=0, sprite_addr, cell_col, cell_row and cell_state are forced to 0.
- Board RAM: 100 x 2 bits, read-first.
  - A write to the cell being read in the same cycle returns the old value; the new value appears on the next read.
  - Writes with wr_col>=GRID_COLS or wr_row>=GRID_ROWS are ignored.
- Clear FSM states:
  - IDLE: clear_req moves to CLEAR with index<=0.
  - CLEAR: writes 0 at index and increments. After index 99 is written, goes to IDLE.
  - clear_busy=1 in CLEAR.
  - During CLEAR, wr_en is ignored, clear_req is ignored, and cell_state is forced to 0.
  - If clear_req and wr_en are asserted in the same IDLE cycle, clear wins and the write is dropped.
- Reset: all outputs 0, offsets and indices 0, FSM enters CLEAR.
  - clear_busy reads 1 from reset assertion until 100 cycles after reset release.
  - Reset asserted mid-sweep restarts the sweep from index 0.

## Timing
- Latency is 2 clk_25 edges. Outputs for the counters sampled at edge k are valid after edge k+1.
- h_sync_out and v_sync_out equal h_sync_in and v_sync_in delayed by exactly 2 cycles, so data stays aligned with sync.
- A write committed at edge k is visible to any stage-2 read at edge k+1 or later.
- A clear pulse at edge k gives clear_busy=1 after edge k and clear_busy=0 after edge k+100.
- Boundary pixels:
  - (145,30) gives sprite_addr 0, col 0, row 0.
  - (494,379) gives sprite_addr 1224, col 9, row 9.
  - (495,y) and (x,380) give in_grid=0.

## Test plan
- Free-running counters from reset, (h,v)=(180,65) -> two cycles later: in_grid=1, col=1, row=1, sprite_addr=0.
- (h,v)=(179,64) -> col=0, row=0, sprite_addr 34+35*34=1224; (144,30) -> in_grid=0, sprite_addr=0; (640,10) -> visible=0.
- Release reset -> clear_busy high for 100 cycles, then write (col 3, row 7)=2 -> the pixel at (250,275) reads cell_state=2; wr_col=10 -> no RAM change.
- Write a cell in the same cycle its pixel is read -> old value output; next frame -> new value.
- clear_req and wr_en together -> write dropped and sweep runs; wr_en mid-sweep ignored; reset at sweep index 50 -> sweep restarts, clear_busy low only 100 cycles after release.
- Compare h_sync_in to h_sync_out over a full frame -> exactly 2-cycle delay, no glitches.
